preset_entry: RTL and testbench

- Operator-facing preset editor for the stopwatch countdown mode.
- Turns four already-debounced push-button levels into two BCD preset digits: preval_2 (tens) and preval_3 (ones).
- Hands the digits to the down counter with a load/ack handshake.
- Drives a digit-select code and a blink strobe so the display mux can flash the digit being edited.

---
 rtl/preset_entry.sv | 141 ++++++++++++++
 tb/tb_preset_entry.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/preset_entry.sv
// Preset editor for the stopwatch countdown mode. Four debounced button
// levels become two BCD preset digits, committed to the down counter with a
// load/ack handshake, plus digit-select and blink outputs for the display mux.
module preset_entry #(
  parameter int unsigned MAX_HI    = 9,
  parameter int unsigned MAX_LO    = 9,
  parameter int unsigned INIT_HI   = 0,
  parameter int unsigned INIT_LO   = 9,
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       r,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic       btn_sel,
  input  logic       btn_set,
  input  logic       load_ack,
  output logic [3:0] preval_2,
  output logic [3:0] preval_3,
  output logic       load,
  output logic [1:0] edit_sel,
  output logic       blink
);

  localparam int unsigned CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EDIT_HI = 2'd1,
    EDIT_LO = 2'd2,
    LOAD    = 2'd3
  } state_t;

  state_t         state, state_n;
  logic [3:0]     hi_n, lo_n;
  logic [3:0]     btn_s, btn_p, pulse;
  logic           armed;
  logic [CW-1:0]  cnt;
  logic           in_edit, edit_n, restart;

  // Bit order of the button vectors: {set, sel, dec, inc}
  logic p_inc, p_dec, p_sel, p_set;
  assign pulse = btn_s & ~btn_p;
  assign p_inc = pulse[0];
  assign p_dec = pulse[1];
  assign p_sel = pulse[2];
  assign p_set = pulse[3];

  // Button synchronisers and history for rising-edge detection.
  // History is held at 1 for the first edge after reset so that a button held
  // through reset does not look like a fresh press when the sync reg fills.
  always_ff @(posedge clk) begin
    if (!r) begin
      btn_s <= '0;
      btn_p <= '1;
      armed <= 1'b0;
    end else begin
      btn_s <= {btn_set, btn_sel, btn_dec, btn_inc};
      btn_p <= armed ? btn_s : btn_p;
      armed <= 1'b1;
    end
  end

  // Next-state and digit arithmetic; set beats sel beats inc/dec.
  always_comb begin
    state_n = state;
    hi_n    = preval_2;
    lo_n    = preval_3;
    case (state)
      IDLE: begin
        if (p_set)      state_n = LOAD;
        else if (p_sel) state_n = EDIT_HI;
      end
      EDIT_HI, EDIT_LO: begin
        if (p_set) begin
          state_n = LOAD;
        end else if (p_sel) begin
          state_n = (state == EDIT_HI) ? EDIT_LO : EDIT_HI;
        end else if (p_inc ^ p_dec) begin
          if (state == EDIT_HI) begin
            if (p_inc) hi_n = (preval_2 == 4'(MAX_HI)) ? 4'd0 : preval_2 + 4'd1;
            else       hi_n = (preval_2 == 4'd0) ? 4'(MAX_HI) : preval_2 - 4'd1;
          end else begin
            if (p_inc) lo_n = (preval_3 == 4'(MAX_LO)) ? 4'd0 : preval_3 + 4'd1;
            else       lo_n = (preval_3 == 4'd0) ? 4'(MAX_LO) : preval_3 - 4'd1;
          end
        end
      end
      LOAD: begin
        if (load_ack) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign in_edit = (state == EDIT_HI) || (state == EDIT_LO);
  assign edit_n  = (state_n == EDIT_HI) || (state_n == EDIT_LO);
  // Counter restarts on a select press or when an edit state is first entered
  assign restart = edit_n && (p_sel || !in_edit);

  // State, digits and registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (!r) begin
      state    <= IDLE;
      preval_2 <= 4'(INIT_HI);
      preval_3 <= 4'(INIT_LO);
      load     <= 1'b0;
      edit_sel <= 2'b00;
    end else begin
      state    <= state_n;
      preval_2 <= hi_n;
      preval_3 <= lo_n;
      load     <= (state_n == LOAD);
      case (state_n)
        EDIT_HI: edit_sel <= 2'b10;
        EDIT_LO: edit_sel <= 2'b01;
        default: edit_sel <= 2'b00;
      endcase
    end
  end

  // Blink divider: runs only while editing, toggles blink on each wrap.
  always_ff @(posedge clk) begin
    if (!r) begin
      cnt   <= '0;
      blink <= 1'b0;
    end else if (!edit_n) begin
      cnt   <= '0;
      blink <= 1'b0;
    end else if (restart) begin
      cnt   <= '0;
      blink <= 1'b1;
    end else if (cnt == CW'(BLINK_DIV - 1)) begin
      cnt   <= '0;
      blink <= ~blink;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_preset_entry.sv
// Directed bench for preset_entry with a short blink period.
module tb_preset_entry;

  logic       clk = 1'b0;
  logic       r, btn_inc, btn_dec, btn_sel, btn_set, load_ack;
  logic [3:0] preval_2, preval_3;
  logic       load, blink;
  logic [1:0] edit_sel;

  int total = 0;
  int bad   = 0;

  preset_entry #(
    .MAX_HI(9), .MAX_LO(9), .INIT_HI(0), .INIT_LO(9), .BLINK_DIV(4)
  ) dut (
    .clk(clk), .r(r), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .btn_sel(btn_sel), .btn_set(btn_set), .load_ack(load_ack),
    .preval_2(preval_2), .preval_3(preval_3), .load(load),
    .edit_sel(edit_sel), .blink(blink)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete press: high for two edges, released for one.
  task automatic press(input int b);
    case (b)
      0: btn_inc = 1'b1;
      1: btn_dec = 1'b1;
      2: btn_sel = 1'b1;
      default: btn_set = 1'b1;
    endcase
    tick(); tick();
    btn_inc = 1'b0; btn_dec = 1'b0; btn_sel = 1'b0; btn_set = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    r = 1'b0; btn_inc = 0; btn_dec = 0; btn_sel = 1'b1; btn_set = 0; load_ack = 0;
    tick(); tick(); tick();
    total++;
    if ({preval_2, preval_3} !== 8'h09) begin
      bad++; $display("FAIL reset_digits got=%h exp=09", {preval_2, preval_3});
    end
    total++;
    if ({load, edit_sel, blink} !== 4'b0000) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=0000", {load, edit_sel, blink});
    end
    r = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    total++;
    if ({load, edit_sel, blink} !== 4'b0000) begin
      bad++; $display("FAIL held_sel_no_pulse got=%b exp=0000", {load, edit_sel, blink});
    end
    btn_sel = 1'b0;
    tick(); tick();
    total++;
    if (edit_sel !== 2'b00) begin
      bad++; $display("FAIL held_sel_release got=%b exp=00", edit_sel);
    end
  endtask

  task automatic test_edit();
    press(2);
    total++;
    if (edit_sel !== 2'b10) begin
      bad++; $display("FAIL enter_edit_hi got=%b exp=10", edit_sel);
    end
    press(0); press(0); press(0);
    total++;
    if (preval_2 !== 4'd3) begin
      bad++; $display("FAIL inc_x3 got=%0d exp=3", preval_2);
    end
    press(2);
    total++;
    if (edit_sel !== 2'b01) begin
      bad++; $display("FAIL toggle_lo got=%b exp=01", edit_sel);
    end
    press(1);
    total++;
    if (preval_3 !== 4'd8) begin
      bad++; $display("FAIL dec_first got=%0d exp=8", preval_3);
    end
    for (int i = 0; i < 8; i++) press(1);
    total++;
    if (preval_3 !== 4'd0) begin
      bad++; $display("FAIL dec_to_zero got=%0d exp=0", preval_3);
    end
    press(1);
    total++;
    if ({preval_2, preval_3, edit_sel} !== {4'd3, 4'd9, 2'b01}) begin
      bad++; $display("FAIL dec_wrap got=%h/%b exp=39/01", {preval_2, preval_3}, edit_sel);
    end
  endtask

  task automatic test_wrap_hi();
    press(2);
    for (int i = 0; i < 6; i++) press(0);
    total++;
    if (preval_2 !== 4'd9) begin
      bad++; $display("FAIL hi_to_max got=%0d exp=9", preval_2);
    end
    press(0);
    total++;
    if (preval_2 !== 4'd0) begin
      bad++; $display("FAIL hi_inc_wrap got=%0d exp=0", preval_2);
    end
    press(1);
    total++;
    if (preval_2 !== 4'd9) begin
      bad++; $display("FAIL hi_dec_wrap got=%0d exp=9", preval_2);
    end
    btn_inc = 1'b1; btn_dec = 1'b1;
    tick(); tick();
    btn_inc = 1'b0; btn_dec = 1'b0;
    tick();
    total++;
    if ({preval_2, preval_3} !== 8'h99) begin
      bad++; $display("FAIL inc_dec_same got=%h exp=99", {preval_2, preval_3});
    end
  endtask

  task automatic test_load_hold();
    btn_set = 1'b1;
    tick(); tick();
    btn_set = 1'b0;
    total++;
    if ({load, edit_sel, blink} !== 4'b1000) begin
      bad++; $display("FAIL load_enter got=%b exp=1000", {load, edit_sel, blink});
    end
    for (int i = 0; i < 20; i++) begin
      btn_inc = (i >= 1 && i < 4);
      btn_sel = (i >= 8 && i < 11);
      tick();
      total++;
      if ({load, preval_2, preval_3, blink} !== {1'b1, 8'h99, 1'b0}) begin
        bad++; $display("FAIL load_hold cyc=%0d got=%b/%h exp=1/99", i, load, {preval_2, preval_3});
      end
    end
    btn_inc = 1'b0; btn_sel = 1'b0;
    load_ack = 1'b1;
    tick();
    load_ack = 1'b0;
    total++;
    if ({load, edit_sel} !== 3'b000) begin
      bad++; $display("FAIL load_ack_drop got=%b exp=000", {load, edit_sel});
    end
    tick(); tick(); tick();
    total++;
    if ({load, edit_sel, preval_2, preval_3} !== {3'b000, 8'h99}) begin
      bad++; $display("FAIL presses_discarded got=%b/%h exp=000/99", {load, edit_sel}, {preval_2, preval_3});
    end
    press(0);
    total++;
    if (preval_2 !== 4'd9) begin
      bad++; $display("FAIL idle_ignores_inc got=%0d exp=9", preval_2);
    end
  endtask

  task automatic test_min_load();
    press(2);
    btn_set = 1'b1;
    tick(); tick();
    total++;
    if (load !== 1'b1) begin
      bad++; $display("FAIL min_load_high got=%b exp=1", load);
    end
    load_ack = 1'b1; btn_set = 1'b0;
    tick();
    load_ack = 1'b0;
    total++;
    if ({load, edit_sel} !== 3'b000) begin
      bad++; $display("FAIL min_load_low got=%b exp=000", {load, edit_sel});
    end
    tick();
  endtask

  task automatic test_blink();
    press(2);
    btn_sel = 1'b1;
    tick(); tick();
    btn_sel = 1'b0;
    total++;
    if ({edit_sel, blink} !== 3'b011) begin
      bad++; $display("FAIL blink_enter_lo got=%b exp=011", {edit_sel, blink});
    end
    for (int j = 1; j <= 21; j++) begin
      tick();
      total++;
      if (blink !== (((j / 4) % 2) == 0)) begin
        bad++; $display("FAIL blink_period j=%0d got=%b exp=%b", j, blink, ((j / 4) % 2) == 0);
      end
    end
    btn_sel = 1'b1;
    tick(); tick();
    btn_sel = 1'b0;
    total++;
    if ({edit_sel, blink} !== 3'b101) begin
      bad++; $display("FAIL blink_restart got=%b exp=101", {edit_sel, blink});
    end
    tick(); tick(); tick();
    total++;
    if (blink !== 1'b1) begin
      bad++; $display("FAIL blink_after_restart got=%b exp=1", blink);
    end
    tick();
    total++;
    if (blink !== 1'b0) begin
      bad++; $display("FAIL blink_first_toggle got=%b exp=0", blink);
    end
    btn_set = 1'b1;
    tick(); tick();
    btn_set = 1'b0;
    total++;
    if ({load, edit_sel, blink} !== 4'b1000) begin
      bad++; $display("FAIL blink_exit got=%b exp=1000", {load, edit_sel, blink});
    end
  endtask

  task automatic test_reset_mid_load();
    r = 1'b0;
    tick();
    total++;
    if ({load, preval_2, preval_3} !== {1'b0, 8'h09}) begin
      bad++; $display("FAIL reset_mid_load got=%b/%h exp=0/09", load, {preval_2, preval_3});
    end
    r = 1'b1;
    tick(); tick();
    press(0);
    total++;
    if ({load, edit_sel, preval_2, preval_3} !== {3'b000, 8'h09}) begin
      bad++; $display("FAIL post_reset_idle got=%b/%h exp=000/09", {load, edit_sel}, {preval_2, preval_3});
    end
  endtask

  initial begin
    test_reset();
    test_edit();
    test_wrap_hi();
    test_load_hold();
    test_min_load();
    test_blink();
    test_reset_mid_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
